// File: rtl/key_pulse_gen.sv
// Push-button conditioner: synchronise and debounce an active-low key, then emit one-cycle
// count-enable pulses per accepted press, plus optional auto-repeat pulses while the key is held.
module key_pulse_gen #(
  parameter int DB_CYCLES     = 1000000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int CNT_W         = 25
) (
  input  logic CP,
  input  logic CLR,
  input  logic KEY_N,
  input  logic REP_EN,
  output logic PULSE,
  output logic LEVEL,
  output logic REP
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_CYCLES - 1);
  // Threshold places the first repeat pulse exactly REPEAT_DELAY cycles after the accept pulse.
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             sync1;
  logic             key_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pulse_nxt;

  always_ff @(posedge CP) begin
    if (CLR) begin
      sync1 <= 1'b0;
      key_s <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
      PULSE <= 1'b0;
      LEVEL <= 1'b0;
      REP   <= 1'b0;
    end else begin
      sync1 <= ~KEY_N;
      key_s <= sync1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      PULSE <= pulse_nxt;
      LEVEL <= (state_nxt == HELD) || (state_nxt == REPEAT) || (state_nxt == RELEASE_WAIT);
      REP   <= (state_nxt == REPEAT);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    pulse_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (key_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
        end
      end
      HELD: begin
        // Release takes priority over a repeat landing on the same cycle.
        if (!key_s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end else if (cnt == DELAY_LAST) begin
          if (REP_EN) begin
            state_nxt = REPEAT;
            cnt_nxt   = '0;
            pulse_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt;
          end
        end
      end
      REPEAT: begin
        if (!key_s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end else if (!REP_EN) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == PERIOD_LAST) begin
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (key_s) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Bench for key_pulse_gen: expected PULSE edges are queued as stimulus is driven and
// consumed by a monitor; level/repeat flags are checked inline by each scenario task.
module tb_key_pulse_gen;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic CP     = 1'b0;
  logic CLR    = 1'b1;
  logic KEY_N  = 1'b0;
  logic REP_EN = 1'b0;
  logic PULSE;
  logic LEVEL;
  logic REP;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_bad  = 0;
  int exp_q[$];

  key_pulse_gen #(
    .DB_CYCLES    (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .CNT_W        (4)
  ) dut (
    .CP    (CP),
    .CLR   (CLR),
    .KEY_N (KEY_N),
    .REP_EN(REP_EN),
    .PULSE (PULSE),
    .LEVEL (LEVEL),
    .REP   (REP)
  );

  always #5 CP = ~CP;

  always @(posedge CP) cyc <= cyc + 1;

  // Scoreboard consumer: a pulse must appear exactly at each queued edge and nowhere else.
  always @(posedge CP) begin
    #1;
    if (exp_q.size() > 0 && exp_q[0] == cyc) begin
      void'(exp_q.pop_front());
      n_cmp++;
      if (PULSE !== 1'b1) begin
        n_bad++;
        $display("FAIL pulse_expected: edge %0d PULSE=%b, required 1", cyc, PULSE);
      end
    end else if (PULSE !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pulse_unexpected: edge %0d PULSE=%b, required 0", cyc, PULSE);
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge CP);
      #1;
    end
  endtask

  task automatic test_reset;
    int e0;
    CLR = 1'b1; KEY_N = 1'b0; REP_EN = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      goto(i);
      n_cmp++;
      if ({PULSE, LEVEL, REP} !== 3'b000) begin
        n_bad++;
        $display("FAIL reset_outputs: edge %0d {PULSE,LEVEL,REP}=%b, required 000", cyc, {PULSE, LEVEL, REP});
      end
    end
    CLR = 1'b0;
    e0 = cyc + 1;
    exp_q.push_back(e0 + 6);
    goto(e0 + 5);
    n_cmp++;
    if (LEVEL !== 1'b0) begin n_bad++; $display("FAIL reset_level_early: LEVEL=%b, required 0", LEVEL); end
    goto(e0 + 6);
    n_cmp++;
    if (LEVEL !== 1'b1) begin n_bad++; $display("FAIL reset_level_rise: LEVEL=%b, required 1", LEVEL); end
    KEY_N = 1'b1;
    goto(cyc + 12);
    n_cmp++;
    if (exp_q.size() != 0 || LEVEL !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_drain: pending=%0d LEVEL=%b, required 0 and 0", exp_q.size(), LEVEL);
    end
  endtask

  task automatic test_clean_press;
    int e0;
    e0 = cyc + 1;
    KEY_N = 1'b0;
    exp_q.push_back(e0 + 6);
    goto(e0 + 6);
    n_cmp++;
    if (LEVEL !== 1'b1) begin n_bad++; $display("FAIL press_level_rise: LEVEL=%b, required 1", LEVEL); end
    goto(e0 + 7);
    KEY_N = 1'b1;
    goto(e0 + 13);
    n_cmp++;
    if (LEVEL !== 1'b1) begin n_bad++; $display("FAIL press_level_hold: LEVEL=%b, required 1", LEVEL); end
    goto(e0 + 14);
    n_cmp++;
    if (LEVEL !== 1'b0) begin n_bad++; $display("FAIL press_level_fall: LEVEL=%b, required 0", LEVEL); end
    goto(e0 + 20);
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL press_drain: pending=%0d, required 0", exp_q.size()); end
  endtask

  task automatic test_bounce;
    int e0;
    int r;
    e0 = cyc + 1;
    KEY_N = 1'b0;
    goto(e0 + 1);
    KEY_N = 1'b1;
    goto(e0 + 2);
    KEY_N = 1'b0;
    goto(e0 + 3);
    KEY_N = 1'b1;
    for (int i = 4; i <= 12; i++) begin
      goto(e0 + i);
      n_cmp++;
      if (LEVEL !== 1'b0) begin
        n_bad++;
        $display("FAIL bounce_level: edge %0d LEVEL=%b, required 0", cyc, LEVEL);
      end
    end
    e0 = cyc + 1;
    KEY_N = 1'b0;
    exp_q.push_back(e0 + 6);
    goto(e0 + 10);
    r = cyc + 1;
    KEY_N = 1'b1;
    goto(r + 1);
    KEY_N = 1'b0;
    goto(r + 2);
    KEY_N = 1'b1;
    goto(r + 8);
    n_cmp++;
    if (LEVEL !== 1'b1) begin n_bad++; $display("FAIL bouncy_release_hold: LEVEL=%b, required 1", LEVEL); end
    goto(r + 9);
    n_cmp++;
    if (LEVEL !== 1'b0) begin n_bad++; $display("FAIL bouncy_release_fall: LEVEL=%b, required 0", LEVEL); end
    goto(r + 14);
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL bounce_drain: pending=%0d, required 0", exp_q.size()); end
  endtask

  task automatic test_auto_repeat;
    int t0;
    REP_EN = 1'b1;
    t0 = cyc + 1 + 6;
    KEY_N = 1'b0;
    exp_q.push_back(t0);
    for (int k = 0; k < 8; k++) exp_q.push_back(t0 + RD + RP * k);
    goto(t0 + 9);
    n_cmp++;
    if (REP !== 1'b0) begin n_bad++; $display("FAIL repeat_rep_early: REP=%b, required 0", REP); end
    goto(t0 + 10);
    n_cmp++;
    if (REP !== 1'b1) begin n_bad++; $display("FAIL repeat_rep_start: REP=%b, required 1", REP); end
    goto(t0 + 31);
    KEY_N = 1'b1;
    goto(t0 + 33);
    n_cmp++;
    if (REP !== 1'b1) begin n_bad++; $display("FAIL repeat_rep_hold: REP=%b, required 1", REP); end
    goto(t0 + 34);
    n_cmp++;
    if ({LEVEL, REP} !== 2'b10) begin
      n_bad++;
      $display("FAIL repeat_release: {LEVEL,REP}=%b, required 10", {LEVEL, REP});
    end
    goto(t0 + 38);
    n_cmp++;
    if (LEVEL !== 1'b0) begin n_bad++; $display("FAIL repeat_level_fall: LEVEL=%b, required 0", LEVEL); end
    goto(t0 + 42);
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL repeat_drain: pending=%0d, required 0", exp_q.size()); end
    REP_EN = 1'b0;
  endtask

  task automatic test_rep_en_toggle;
    int t0;
    REP_EN = 1'b1;
    t0 = cyc + 1 + 6;
    KEY_N = 1'b0;
    exp_q.push_back(t0);
    exp_q.push_back(t0 + 10);
    exp_q.push_back(t0 + 13);
    goto(t0 + 14);
    n_cmp++;
    if (REP !== 1'b1) begin n_bad++; $display("FAIL toggle_rep_on: REP=%b, required 1", REP); end
    REP_EN = 1'b0;
    goto(t0 + 15);
    n_cmp++;
    if ({LEVEL, REP} !== 2'b10) begin
      n_bad++;
      $display("FAIL toggle_rep_drop: {LEVEL,REP}=%b, required 10", {LEVEL, REP});
    end
    exp_q.push_back(t0 + 25);
    exp_q.push_back(t0 + 28);
    exp_q.push_back(t0 + 31);
    goto(t0 + 20);
    REP_EN = 1'b1;
    goto(t0 + 24);
    n_cmp++;
    if (REP !== 1'b0) begin n_bad++; $display("FAIL toggle_rep_wait: REP=%b, required 0", REP); end
    goto(t0 + 25);
    n_cmp++;
    if (REP !== 1'b1) begin n_bad++; $display("FAIL toggle_rep_restart: REP=%b, required 1", REP); end
    goto(t0 + 31);
    KEY_N = 1'b1;
    goto(t0 + 40);
    n_cmp++;
    if (exp_q.size() != 0 || LEVEL !== 1'b0) begin
      n_bad++;
      $display("FAIL toggle_drain: pending=%0d LEVEL=%b, required 0 and 0", exp_q.size(), LEVEL);
    end
    REP_EN = 1'b0;
  endtask

  task automatic test_reset_mid_repeat;
    int t0;
    REP_EN = 1'b1;
    t0 = cyc + 1 + 6;
    KEY_N = 1'b0;
    exp_q.push_back(t0);
    exp_q.push_back(t0 + 10);
    exp_q.push_back(t0 + 13);
    goto(t0 + 14);
    CLR = 1'b1;
    goto(t0 + 15);
    n_cmp++;
    if ({PULSE, LEVEL, REP} !== 3'b000) begin
      n_bad++;
      $display("FAIL midreset_outputs: {PULSE,LEVEL,REP}=%b, required 000", {PULSE, LEVEL, REP});
    end
    CLR = 1'b0;
    exp_q.push_back(t0 + 22);
    exp_q.push_back(t0 + 32);
    exp_q.push_back(t0 + 35);
    goto(t0 + 21);
    n_cmp++;
    if (LEVEL !== 1'b0) begin n_bad++; $display("FAIL midreset_level_wait: LEVEL=%b, required 0", LEVEL); end
    goto(t0 + 22);
    n_cmp++;
    if (LEVEL !== 1'b1) begin n_bad++; $display("FAIL midreset_level_rise: LEVEL=%b, required 1", LEVEL); end
    goto(t0 + 32);
    n_cmp++;
    if (REP !== 1'b1) begin n_bad++; $display("FAIL midreset_rep_resume: REP=%b, required 1", REP); end
    goto(t0 + 35);
    KEY_N = 1'b1;
    goto(t0 + 38);
    n_cmp++;
    if (REP !== 1'b0) begin n_bad++; $display("FAIL midreset_rep_release: REP=%b, required 0", REP); end
    goto(t0 + 44);
    n_cmp++;
    if (exp_q.size() != 0 || LEVEL !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_drain: pending=%0d LEVEL=%b, required 0 and 0", exp_q.size(), LEVEL);
    end
    REP_EN = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_rep_en_toggle();
    test_reset_mid_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
